// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   ctrl_state_t       : controller FSM state encoding (also exported on
//                        the ctrl_state debug port)
//   REG_ADDR_W_DEFAULT : default register-address width (8-entry file)
//   NOP_INSTR          : bubble encoding loaded into ID-EX by the buffer
//                        when idex_bubble is asserted
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } ctrl_state_t;

  localparam int REG_ADDR_W_DEFAULT = 3;

  // addi x0, x0, 0 -- the ID-EX buffer substitutes this on a bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// ---------------------------------------------------------------------------
// hazard_sat_counter
// Up-counter that holds at MAX, with a synchronous clear that wins over
// increment. Used for the memory-wait length and the optional statistics.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear
//   inc   : count up by one (ignored once count == MAX)
//   count : current value
// ---------------------------------------------------------------------------
module hazard_sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// Pipeline sequencing controller: resolves the hazards operand forwarding
// cannot (load-use, taken branch, multi-cycle memory) by gating the PC and
// IF-ID write enables, inserting ID-EX bubbles and flushing IF-ID.
// Outputs are Mealy (current state + inputs); priority is
// mem_busy > branch_taken > load_use.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   id_src, id_dst  : decode-stage operand registers
//   id_uses_src/dst : decode instruction actually reads that register
//   ex_mem_read     : ID-EX instruction is a load
//   ex_dst          : ID-EX destination register
//   branch_taken    : EX resolved a taken branch this cycle
//   mem_busy        : data memory needs more cycles
//   pc_write_en     : PC may update
//   ifid_write_en   : IF-ID may load
//   idex_bubble     : load NOP into ID-EX
//   ifid_flush      : clear IF-ID
//   mem_stall       : freeze all buffers up to and including EX-MEM
//   mem_timeout     : sticky, set once a wait reaches MEM_TIMEOUT cycles
//   ctrl_state      : current FSM state (debug)
//
// Optional build macro HAZARD_STATS_EN adds:
//   stat_clear            : synchronous clear of the statistics
//   stat_load_stalls      : cycles spent in load-use stall
//   stat_flush_cycles     : cycles with IF-ID/ID-EX flushed
//   stat_mem_wait_cycles  : cycles frozen on mem_busy
// Each is a 16-bit saturating counter.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RUN        | normal issue; load-use / branch / memory hazards detected here
// LOAD_STALL | one cycle after a load-use stall, load now in EX-MEM
// FLUSH      | squashing wrong-path instructions, flush_cnt cycles left
// MEM_WAIT   | frozen on mem_busy; ret_state says where to resume
// ---------------------------------------------------------------------------
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_uses_src,
  input  logic                  id_uses_dst,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  mem_stall,
  output logic                  mem_timeout,
  output logic [1:0]            ctrl_state
`ifdef HAZARD_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [15:0]           stat_load_stalls,
  output logic [15:0]           stat_flush_cycles,
  output logic [15:0]           stat_mem_wait_cycles
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);
  localparam logic [7:0] WAIT_MAX_M1  = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [2:0]  flush_cnt, flush_nxt;
  logic [7:0]  wait_cnt;
  logic        wait_inc, wait_clr;
  logic        load_use;

  assign load_use = ex_mem_read &
                    ((id_uses_src & (id_src == ex_dst)) |
                     (id_uses_dst & (id_dst == ex_dst)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      ret_state   <= RUN;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      flush_cnt <= flush_nxt;
      // wait_cnt reaches MAX on this edge
      if (wait_inc && (wait_cnt >= WAIT_MAX_M1)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    mem_stall     = 1'b0;
    state_nxt     = state;
    ret_nxt       = ret_state;
    flush_nxt     = flush_cnt;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    eff_state     = state;

    // In the release cycle of a wait the controller behaves exactly as the
    // state it returns to, so that state's decision logic is reused below.
    if (state == MEM_WAIT) begin
      if (mem_busy) begin
        mem_stall     = 1'b1;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        wait_inc      = 1'b1;
      end else begin
        wait_clr  = 1'b1;
        eff_state = ret_state;
        state_nxt = ret_state;
      end
    end

    case (eff_state)
      RUN, LOAD_STALL: begin
        state_nxt = RUN;
        if (mem_busy) begin
          mem_stall     = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          wait_inc      = 1'b1;
          ret_nxt       = RUN;
          state_nxt     = MEM_WAIT;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            flush_nxt = FLUSH_RELOAD;
          end
        end else if (load_use && (eff_state == RUN)) begin
          // In LOAD_STALL the bubble occupies ID-EX, so load_use is masked.
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
          state_nxt     = LOAD_STALL;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          // flush_cnt is held so the flush resumes where it stopped
          mem_stall     = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          wait_inc      = 1'b1;
          ret_nxt       = FLUSH;
          state_nxt     = MEM_WAIT;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            flush_nxt = FLUSH_RELOAD;
          end else if (flush_cnt <= 3'd1) begin
            state_nxt = RUN;
          end else begin
            flush_nxt = flush_cnt - 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  hazard_sat_counter #(
    .WIDTH (8),
    .MAX   (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  assign ctrl_state = state;

`ifdef HAZARD_STATS_EN
  logic load_stall;

  // the only case with a bubble but no flush and no memory freeze
  assign load_stall = idex_bubble & ~ifid_flush & ~mem_stall;

  hazard_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_load (
    .clk(clk), .rst(rst), .clr(stat_clear), .inc(load_stall), .count(stat_load_stalls)
  );

  hazard_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_flush (
    .clk(clk), .rst(rst), .clr(stat_clear), .inc(ifid_flush), .count(stat_flush_cycles)
  );

  hazard_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_mem (
    .clk(clk), .rst(rst), .clr(stat_clear), .inc(mem_stall), .count(stat_mem_wait_cycles)
  );
`endif

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller beside the ALU operand-forwarding logic.
- Detects hazards that forwarding cannot resolve: load-use, taken branch and multi-cycle memory wait.
- Drives PC / IF-ID write enables, the ID-EX bubble and the flush controls.
- Single FSM with one clock; every decision is defined at cycle level.

Parameters:
- REG_ADDR_W, 3: register-address width (8-entry register file).
- FLUSH_CYCLES, 2: number of cycles IF-ID and ID-EX are flushed after a taken branch; legal range 1..7.
- MEM_TIMEOUT, 15: maximum consecutive mem_busy cycles before mem_timeout is raised; legal range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_src  in  REG_ADDR_W  source register of the instruction in decode.
- id_dst  in  REG_ADDR_W  destination/first-operand register of the instruction in decode.
- id_uses_src  in  1  decode instruction reads id_src.
- id_uses_dst  in  1  decode instruction reads id_dst as an operand.
- ex_mem_read  in  1  instruction in the ID-EX buffer is a load.
- ex_dst  in  REG_ADDR_W  destination of the ID-EX instruction.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- mem_busy  in  1  data memory needs more cycles.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF-ID buffer may load.
- idex_bubble  out  1  load a NOP into ID-EX.
- ifid_flush  out  1  clear IF-ID.
- mem_stall  out  1  freeze all buffers up to and including EX-MEM.
- mem_timeout  out  1  sticky error flag.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- Reset values: state RUN; flush_cnt 0; wait_cnt 0; mem_timeout 0.
- Reset output values: pc_write_en 1, ifid_write_en 1, idex_bubble 0, ifid_flush 0, mem_stall 0.
- rst asserted mid-operation aborts any stall or flush immediately; no residual bubbles follow.
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- Outputs are Mealy: combinational from the current state and inputs. The state, counters and flag are registered on the posedge of clk.
- load_use = ex_mem_read & ((id_uses_src & id_src==ex_dst) | (id_uses_dst & id_dst==ex_dst)).
- Priority within a cycle: mem_busy > branch_taken > load_use.
- RUN behaviour:
  - mem_busy: assert mem_stall, pc_write_en=0, ifid_write_en=0; next state MEM_WAIT; wait_cnt=1.
  - Else branch_taken: assert ifid_flush and idex_bubble. If FLUSH_CYCLES>1, next state FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else load_use: pc_write_en=0, ifid_write_en=0, idex_bubble=1; next state LOAD_STALL.
  - Otherwise all enables are 1 and there are no bubbles.
- LOAD_STALL lasts exactly one cycle. Outputs are as in RUN, re-evaluated on the now-advanced load. A second load_use cannot occur because the bubble is in ID-EX. Next state RUN.
  - Exception: if mem_busy asserts in this state, go to MEM_WAIT.
- FLUSH behaviour:
  - ifid_flush=1, idex_bubble=1, pc_write_en=1; flush_cnt decrements each cycle; return to RUN when flush_cnt reaches 1.
  - load_use is ignored, since the decode instruction is being flushed.
  - A new branch_taken reloads flush_cnt.
  - mem_busy takes precedence: go to MEM_WAIT. The flush resumes with the remaining count after the wait; a 2-bit saved return state selects this.
- MEM_WAIT behaviour:
  - mem_stall=1, pc_write_en=0, ifid_write_en=0, idex_bubble=0.
  - wait_cnt increments and saturates at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_timeout, which stays set until rst.
  - When mem_busy deasserts: return to the saved state (RUN or FLUSH); wait_cnt=0. In the release cycle, outputs are those of the return state.
- Register equality is full REG_ADDR_W compare.
- No forwarding decisions are made here; forwarding stays in its own unit.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stat_load_stalls, stat_flush_cycles and stat_mem_wait_cycles, each 16 bit.
  - Each is a saturating counter (holds at 16'hFFFF), incremented once per cycle spent in the respective stall type, cleared by rst.
  - Adds input stat_clear (1 bit), a synchronous zero with priority over increment.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - ctrl_state_t enum (RUN, LOAD_STALL, FLUSH, MEM_WAIT).
  - REG_ADDR_W default.
  - The NOP/bubble encoding constant shared with the ID-EX buffer.
- One sub-module, hazard_sat_counter: a parameterised-width saturating counter with clear. It is used for wait_cnt and, when HAZARD_STATS_EN is defined, for the three statistics counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=3, id_src=3, id_uses_src=1 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1; ctrl_state=1, then RUN; no second bubble.
- No hazard: ex_mem_read=1, ex_dst=3, id_src=3, id_uses_src=0 and id_dst=5 -> all enables 1, idex_bubble=0.
- Branch: branch_taken for 1 cycle with FLUSH_CYCLES=2 -> ifid_flush=1 and idex_bubble=1 for exactly 2 cycles, then RUN.
- Priority: branch_taken, load_use and mem_busy asserted together -> MEM_WAIT with mem_stall=1. After mem_busy drops, ctrl_state returns to RUN.
- Timeout: mem_busy held for 20 cycles with MEM_TIMEOUT=15 -> mem_timeout rises after the 15th busy cycle and stays 1 after mem_busy drops. rst pulse -> all outputs at reset values, ctrl_state=0.
- HAZARD_STATS_EN: run the three previous scenarios -> stat_load_stalls=1, stat_flush_cycles=2, stat_mem_wait_cycles=20; stat_clear -> all 0 next cycle.
